// File: rtl/majority_voter_monitor.sv
// ============================================================================
// Module   : majority_voter_monitor
// Brief    : Bit-wise TMR majority voter with per-replica fault monitoring
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module majority_voter_monitor #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8,
  parameter int PIPELINE  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     inA,
  input  logic [WIDTH-1:0]     inB,
  input  logic [WIDTH-1:0]     inC,
  input  logic                 clrCnt,
  output logic [WIDTH-1:0]     out,
  output logic                 tmrErr,
  output logic                 faultA,
  output logic                 faultB,
  output logic                 faultC,
  output logic                 multiErr,
  output logic                 stickyA,
  output logic                 stickyB,
  output logic                 stickyC,
  output logic [CNT_WIDTH-1:0] errCntA,
  output logic [CNT_WIDTH-1:0] errCntB,
  output logic [CNT_WIDTH-1:0] errCntC
);

  localparam logic [CNT_WIDTH-1:0] c_one  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] c_ones = {CNT_WIDTH{1'b1}};

  logic [WIDTH-1:0]     w_maj;
  logic [WIDTH-1:0]     w_min_a;
  logic [WIDTH-1:0]     w_min_b;
  logic [WIDTH-1:0]     w_min_c;
  logic [2:0]           w_f;
  logic                 w_any;
  logic                 w_multi;
  logic [CNT_WIDTH-1:0] w_cnt [3];
  logic                 w_sticky [3];

  logic                 r_tmr;
  logic [2:0]           r_fault;
  logic                 r_multi;

  assign w_maj   = (inA & inB) | (inB & inC) | (inA & inC);
  // A replica is minority on a bit when it differs while the other two agree
  assign w_min_a = (inA ^ inB) & ~(inB ^ inC);
  assign w_min_b = (inB ^ inA) & ~(inA ^ inC);
  assign w_min_c = (inC ^ inA) & ~(inA ^ inB);

  assign w_f     = {|w_min_c, |w_min_b, |w_min_a};
  assign w_any   = |w_f;
  assign w_multi = (w_f[0] & w_f[1]) | (w_f[1] & w_f[2]) | (w_f[0] & w_f[2]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmr   <= 1'b0;
      r_fault <= 3'b000;
      r_multi <= 1'b0;
    end else begin
      r_tmr   <= w_any;
      r_fault <= w_f;
      r_multi <= w_multi;
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_replica
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_sticky;

    // A fault coinciding with a clear is kept as the first count after it
    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt    <= '0;
        r_sticky <= 1'b0;
      end else if (clrCnt) begin
        r_cnt    <= w_f[k] ? c_one : '0;
        r_sticky <= w_f[k];
      end else if (w_f[k]) begin
        r_sticky <= 1'b1;
        if (r_cnt != c_ones) begin
          r_cnt <= r_cnt + c_one;
        end
      end
    end

    assign w_cnt[k]    = r_cnt;
    assign w_sticky[k] = r_sticky;
  end

  if (PIPELINE != 0) begin : g_out_reg
    logic [WIDTH-1:0] r_out;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_out <= '0;
      end else begin
        r_out <= w_maj;
      end
    end

    assign out = r_out;
  end else begin : g_out_comb
    assign out = w_maj;
  end

  assign tmrErr   = r_tmr;
  assign faultA   = r_fault[0];
  assign faultB   = r_fault[1];
  assign faultC   = r_fault[2];
  assign multiErr = r_multi;
  assign stickyA  = w_sticky[0];
  assign stickyB  = w_sticky[1];
  assign stickyC  = w_sticky[2];
  assign errCntA  = w_cnt[0];
  assign errCntB  = w_cnt[1];
  assign errCntC  = w_cnt[2];

endmodule

`default_nettype wire

// File: doc/majority_voter_monitor.md
# majority_voter_monitor

Parametrised TMR majority voter with registered error monitoring for the ETROC2 readout. It votes three replicas of a WIDTH-bit bus bit-wise, with an optional output register. Per cycle, it identifies which replica disagrees with the majority and keeps saturating per-replica fault counters plus sticky flags. Slow control reads and clears these to locate SEU-prone replicas.

## Interface
- WIDTH, 8: bus width voted bit-wise.
- CNT_WIDTH, 8: width of each per-replica fault counter; minimum 2.
- PIPELINE, 0: 0 = `out` combinational from inputs; 1 = `out` registered.

Ports (clock and reset first):
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  synchronous, active-high.
- inA, inB, inC  input  WIDTH  replica buses.
- clrCnt  input  1  synchronous clear of counters and sticky flags.
- out  output  WIDTH  bit-wise majority of inA/inB/inC.
- tmrErr  output  1  registered; high the cycle after any bit mismatch.
- faultA, faultB, faultC  output  1  registered; replica was the minority on at least one bit in the previous cycle.
- multiErr  output  1  registered; more than one replica was minority on different bits in the same cycle.
- stickyA, stickyB, stickyC  output  1  set on fault, held until clrCnt or reset.
- errCntA, errCntB, errCntC  output  CNT_WIDTH  saturating count of fault cycles per replica.

## Operation
- Per bit i: maj[i] = inA&inB | inB&inC | inA&inC.
- Minority flags:
  - minA[i] = (inA[i] != inB[i]) & (inB[i] == inC[i]);
  - minB[i] and minC[i] are defined analogously.
  - At most one of the three is set per bit.
- Raw per-cycle flags: fA = |minA, fB = |minB, fC = |minC.
- Derived flags:
  - anyErr = fA | fB | fC.
  - multi = at least two of fA, fB, fC set.
- Registered outputs, every cycle:
  - tmrErr <= anyErr.
  - faultX <= fX.
  - multiErr <= multi.
- Counters, per replica X, in priority order:
  - reset: cleared to 0.
  - clrCnt: errCntX <= fX ? 1 : 0. A fault in the clear cycle is counted, not lost.
  - fX and errCntX != all-ones: increment by 1.
  - otherwise: hold. The counter saturates at 2^CNT_WIDTH-1 and never wraps.
- Sticky flags:
  - reset: cleared to 0.
  - clrCnt: stickyX <= fX.
  - fX: set to 1.
  - otherwise: hold.
- Counting is per cycle, not per bit. A replica wrong on 5 bits in one cycle increments its counter by 1.
- Voting is unaffected by reset or clrCnt. `out` is always the majority, so a single faulty replica never corrupts it.
- No internal state machine beyond counters/sticky; monitoring runs continuously.

## Timing
- PIPELINE=0:
  - `out` follows the inputs combinationally, zero latency.
  - `out` does not depend on reset.
- PIPELINE=1:
  - `out` is registered, one cycle latency.
  - Reset value of `out` is 0.
- Error outputs (tmrErr, faultX, multiErr): always one cycle after the input sample, independent of PIPELINE.
- Sticky flags and counters: reflect the cycle-N input at cycle N+1.
- Reset values: all registered outputs are 0; this includes errCnt*, sticky*, fault*, tmrErr and multiErr.
- Reset asserted mid-operation: all monitoring state returns to 0 on that edge. Input faults present during the reset cycle are not counted.
- Reset and clrCnt together: reset wins; everything goes to 0.
- clrCnt held for several cycles: each cycle reloads 0 or 1 per the rule above, so no accumulation occurs.

## Test plan
- Clean vote:
  - Stimulus: WIDTH=8; inA=inB=inC=0xA5 for 10 cycles after reset.
  - Required: out=0xA5; tmrErr=0; all counters 0; sticky 0.
- Single upset:
  - Stimulus: one cycle with inB=0xA4, inA=inC=0xA5.
  - Required: out=0xA5 throughout; next cycle tmrErr=1, faultB=1, multiErr=0, errCntB=1, stickyB=1.
  - Required: one cycle later, tmrErr=faultB=0 while stickyB stays 1.
- Multi-replica fault:
  - Stimulus: inA=0x01, inB=0x80, inC=0x00 for one cycle.
  - Required: out=0x00; next cycle faultA=faultB=1, faultC=0, multiErr=1, errCntA=errCntB=1.
- Saturation:
  - Stimulus: CNT_WIDTH=4; inC differs from inA=inB for 20 consecutive cycles.
  - Required: errCntC climbs to 15 and holds; no wrap to 0.
- Clear with concurrent fault:
  - Stimulus: errCntA=7, then clrCnt=1 in a cycle where inA is minority.
  - Required: errCntA=1 and stickyA=1 after the edge.
  - Required: with no fault in the clear cycle, errCntA=0 and stickyA=0.
- Reset and pipeline:
  - Stimulus: PIPELINE=1; assert reset mid-stream with counters nonzero.
  - Required: the next edge forces out, counters, sticky and error outputs to 0.
  - Required: after release, out equals the majority with exactly 1-cycle latency.
